// File: rtl/apb_cmd_master.sv
// apb_cmd_master: converts a valid/ready command into one APB transfer and
// returns a valid/ready response. One transfer is outstanding at a time, and a
// completer that never raises PREADY ends the transfer by timeout.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // max ACCESS cycles waiting for PREADY, 1..255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state logic; APB inputs are only looked at in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY takes priority over a timeout landing in the same cycle.
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_inc == TMO) begin
          cnt_d   = cnt_inc;
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // cmd_ready is masked by PRESET so nothing is accepted during reset.
  assign cmd_ready   = (state_q == S_IDLE) && !PRESET;
  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS);
  assign rsp_valid   = (state_q == S_RESP);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set address width of cmd_addr and PADDR.
REQ-002 Parameter DATA_W, default 32, SHALL set data width of cmd_wdata, PWDATA, PRDATA and rsp_rdata.
REQ-003 Parameter TIMEOUT, default 16, SHALL set max ACCESS cycles waiting for PREADY (legal range 1..255).
REQ-004 PCLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 PRESET  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a PCLK edge.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  transfer address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high on a PCLK edge.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-014 rsp_err  out  1  PSLVERR seen or timeout.
REQ-015 rsp_timeout  out  1  transfer ended by timeout.
REQ-016 PADDR  out  ADDR_W;  PWRITE  out  1;  PSEL  out  1;  PENABLE  out  1;  PWDATA  out  DATA_W  APB requester outputs.
REQ-017 PRDATA  in  DATA_W;  PREADY  in  1;  PSLVERR  in  1  APB completer inputs.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; exactly one active.
REQ-019 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on handshake SHALL register cmd_write/cmd_addr/cmd_wdata and go to SETUP.
REQ-020 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP (one outstanding transfer).
REQ-021 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = registered values; SHALL go to ACCESS after exactly one cycle.
REQ-022 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay constant.
REQ-023 ACCESS with PREADY=1: SHALL capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err, rsp_timeout=0, go to RESP.
REQ-024 Wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with PREADY=0; when it reaches TIMEOUT with PREADY still 0, SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 PREADY=1 in the same cycle the counter hits TIMEOUT SHALL count as normal completion (REQ-023 wins).
REQ-026 RESP: PSEL=0, PENABLE=0, rsp_valid=1, rsp fields stable; on rsp_ready=1 SHALL go to IDLE.
REQ-027 Minimum latency, cmd handshake to rsp_valid with PREADY=1 in first ACCESS: 3 cycles (SETUP, ACCESS, RESP on 3rd edge).
REQ-028 Back-to-back: next command SHALL be accepted no earlier than the cycle after rsp handshake (IDLE one cycle minimum).
REQ-029 PADDR/PWRITE/PWDATA SHALL hold last values in IDLE/RESP (no glitch to 0).
REQ-030 PREADY, PSLVERR, PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-031 PRESET=1 on a PCLK edge SHALL force IDLE regardless of state, including mid-ACCESS.
REQ-032 Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0; cmd_ready=0 while PRESET=1, 1 the first cycle after.
REQ-033 A transfer aborted by reset SHALL produce no response.

Verification
REQ-034 Write addr 0x10 data 0xFFFF, PREADY=1 -> PSEL,PENABLE sequence 10 then 11 for one cycle each, PWDATA=0xFFFF, rsp_valid on 3rd edge, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x4, PREADY low 2 ACCESS cycles then high with PRDATA=0xA5A5_0001 -> ACCESS lasts 3 cycles, rsp_rdata=0xA5A5_0001, rsp_err=0.
REQ-036 Write with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-037 TIMEOUT=4, PREADY held 0 -> exits ACCESS after 4 cycles, rsp_err=1, rsp_timeout=1; PREADY=1 on the 4th cycle instead -> normal completion.
REQ-038 PRESET asserted in 2nd ACCESS cycle -> next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after release.
REQ-039 rsp_ready held 0 for 5 cycles with cmd_valid held 1 -> rsp_valid and fields stable, cmd_ready=0 throughout, second command accepted only after rsp handshake plus one IDLE cycle.
